// File: rtl/alu_multiciclo_if.sv
// Request/response bundle between the control unit and the multi-cycle execute unit.
// The control unit drives the master side; the execute unit is the slave.
interface alu_multiciclo_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, op, A, B,
        input  result, zero, carry, overflow, busy, done
    );

    modport slave (
        input  start, op, A, B,
        output result, zero, carry, overflow, busy, done
    );
endinterface

// File: rtl/alu_multiciclo.sv
// Multi-cycle execute unit: latches operands on start, computes single-cycle ALU ops or a
// shift-add multiply, and returns a registered result and flags with a busy/done handshake.
module alu_multiciclo #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_ITER = 32
) (
    input logic             clk,
    input logic             reset,
    alu_multiciclo_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MUL_ITER);
    localparam int unsigned SH_W  = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_LUI  = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_e;

    state_e           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             carry_q;
    logic             overflow_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   sum_d;
    logic [WIDTH:0]   diff_d;
    logic [WIDTH-1:0] res_d;
    logic             zero_d;
    logic             carry_d;
    logic             overflow_d;
    logic [WIDTH-1:0] acc_d;

    // Single-cycle datapath on the latched operands
    always_comb begin
        res_d      = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        zero_d     = 1'b0;
        sum_d      = {1'b0, a_q} + {1'b0, b_q};
        diff_d     = {1'b0, a_q} - {1'b0, b_q};
        case (op_q)
            OP_ADD: begin
                res_d      = sum_d[WIDTH-1:0];
                carry_d    = sum_d[WIDTH];
                overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_d      = diff_d[WIDTH-1:0];
                carry_d    = ~diff_d[WIDTH];
                overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  res_d = a_q & b_q;
            OP_OR:   res_d = a_q | b_q;
            OP_XOR:  res_d = a_q ^ b_q;
            OP_NOR:  res_d = ~(a_q | b_q);
            OP_SLT:  res_d = WIDTH'($signed(a_q) < $signed(b_q));
            OP_SLTU: res_d = WIDTH'(a_q < b_q);
            OP_SLL:  res_d = a_q << b_q[SH_W-1:0];
            OP_SRL:  res_d = a_q >> b_q[SH_W-1:0];
            OP_SRA:  res_d = $unsigned($signed(a_q) >>> b_q[SH_W-1:0]);
            OP_LUI:  res_d = b_q << (WIDTH / 2);
            default: res_d = '0;
        endcase
        // Reserved opcodes report every flag low, including zero
        if (op_q <= OP_LUI) begin
            zero_d = (res_d == '0);
        end
    end

    assign acc_d = acc_q + (b_q[0] ? a_q : '0);

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        op_q    <= bus.op;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (bus.op == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_q   <= res_d;
                    zero_q     <= zero_d;
                    carry_q    <= carry_d;
                    overflow_q <= overflow_d;
                    state_q    <= S_DONE;
                end
                S_MUL: begin
                    acc_q <= acc_d;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MUL_ITER - 1)) begin
                        result_q   <= acc_d;
                        zero_q     <= (acc_d == '0);
                        carry_q    <= 1'b0;
                        overflow_q <= 1'b0;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    // First DONE cycle lets the new result settle; done pulses in the second
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo: directed corner cases plus random operations
// compared against a plain-arithmetic reference model, including latency and handshake.
module tb_alu_multiciclo;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_SLTU = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_LUI  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_multiciclo_if bus ();

    alu_multiciclo dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the opcode table, using 64-bit arithmetic
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] wide;
        e = '0;
        case (op)
            4'h0: begin
                wide  = 64'(a) + 64'(b);
                e.res = wide[31:0];
                e.c   = wide[32];
                e.v   = (a[31] == b[31]) && (e.res[31] != a[31]);
            end
            4'h1: begin
                e.res = a - b;
                e.c   = (a >= b);
                e.v   = (a[31] != b[31]) && (e.res[31] != a[31]);
            end
            4'h2: e.res = a & b;
            4'h3: e.res = a | b;
            4'h4: e.res = a ^ b;
            4'h5: e.res = ~(a | b);
            4'h6: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h7: e.res = (a < b) ? 32'd1 : 32'd0;
            4'h8: e.res = a << b[4:0];
            4'h9: e.res = a >> b[4:0];
            4'hA: e.res = $signed(a) >>> b[4:0];
            4'hB: e.res = {b[15:0], 16'h0000};
            4'hC: begin
                wide  = 64'(a) * 64'(b);
                e.res = wide[31:0];
            end
            default: e.res = '0;
        endcase
        e.z = (op <= 4'hC) && (e.res == 32'd0);
        return e;
    endfunction

    // inject: 0 none, 1 random start pulses while busy, 2 pulses at MUL cycles 5 and 20
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject);
        exp_t e;
        int   lat;
        int   first_done;
        int   n_done;
        bit   busy_ok;
        e          = model(op, a, b);
        lat        = (op == OP_MUL) ? 33 : 2;
        first_done = -1;
        n_done     = 0;
        busy_ok    = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        for (int k = 0; k <= lat + 1; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            if (k <= lat && bus.busy !== 1'b1) busy_ok = 1'b0;
            if (k == lat) begin
                check_eq($sformatf("res op%0h", op), bus.result, e.res);
                check_eq($sformatf("zero op%0h", op), 32'(bus.zero), 32'(e.z));
                check_eq($sformatf("carry op%0h", op), 32'(bus.carry), 32'(e.c));
                check_eq($sformatf("ovf op%0h", op), 32'(bus.overflow), 32'(e.v));
            end
            // Inputs wander while busy; none of it may affect the result
            bus.A  = $urandom;
            bus.B  = $urandom;
            bus.op = OP_ADD;
            case (inject)
                1:       bus.start = (k < lat) && ($urandom_range(0, 3) == 0);
                2:       bus.start = (k == 4) || (k == 19);
                default: bus.start = 1'b0;
            endcase
        end
        bus.start = 1'b0;
        check_eq($sformatf("done_lat op%0h", op), 32'(first_done), 32'(lat));
        check_eq($sformatf("done_cnt op%0h", op), 32'(n_done), 32'd1);
        check_eq($sformatf("busy_span op%0h", op), 32'(busy_ok), 32'd1);
        check_eq($sformatf("busy_idle op%0h", op), 32'(bus.busy), 32'd0);
        check_eq($sformatf("done_idle op%0h", op), 32'(bus.done), 32'd0);
        check_eq($sformatf("hold op%0h", op), bus.result, e.res);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_res"}, bus.result, 32'd0);
        check_eq({tag, "_flags"}, {28'd0, bus.zero, bus.carry, bus.overflow, bus.busy}, 32'd0);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int n_done;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset held two edges with start asserted: reset must win
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.A     = 32'h0000_0001;
        bus.B     = 32'h0000_0002;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset     = 1'b0;
        bus.start = 1'b0;

        run_op(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op(OP_SUB,  32'd5,         32'd5,         0);
        run_op(OP_SRA,  32'h8000_0000, 32'd4,         0);
        run_op(OP_SRL,  32'h8000_0000, 32'd4,         0);
        run_op(OP_SLT,  32'hFFFF_FFFF, 32'd1,         0);
        run_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1,         0);
        run_op(OP_LUI,  32'h0000_0000, 32'h0000_1234, 0);
        run_op(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(OP_SUB,  32'h8000_0000, 32'h0000_0001, 0);
        run_op(OP_MUL,  32'h0001_0003, 32'h0000_0005, 0);
        run_op(OP_MUL,  32'hFFFF_FFFF, 32'h0000_0002, 2);
        run_op(4'hE,    32'h1234_5678, 32'h1111_1111, 0);

        // Reset after roughly ten multiply iterations aborts the operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.A     = 32'h0000_0007;
        bus.B     = 32'h0000_0009;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("midmul");
        check_eq("midmul_busy", 32'(bus.busy), 32'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
        end
        check_eq("midmul_quiet", 32'(n_done), 32'd0);
        run_op(OP_ADD, 32'd2, 32'd3, 0);

        // Random operations with corner-biased operands
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : 32'($urandom);
            rb  = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            if ($urandom_range(0, 5) == 0) rb = ra;
            run_op(rop, ra, rb, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
